ws2812_encoder: RTL and testbench

Serialises one 24-bit GRB pixel per LED into the WS2812 single-wire waveform at 12 MHz. Sits directly downstream of the LED selector: it consumes the selector's `led_selected`, `led_counter` and `done` pulses, fetches the pixel from the frame buffer, and drives `dout`. It returns `led_clock` to the selector to advance to the next LED and appends the strip latch gap after the last LED.

---
 rtl/ws2812_encoder_if.sv | 25 ++
 rtl/ws2812_encoder.sv | 162 ++++++++++++++++
 tb/tb_ws2812_encoder.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ws2812_encoder_if.sv
// Connects the WS2812 encoder to the LED selector and the frame buffer.
// The line outputs (dout, busy, overrun) also travel here so one handle carries the whole block.
interface ws2812_encoder_if;
  logic        led_selected;
  logic [7:0]  led_counter;
  logic        done;
  logic [7:0]  pixel_addr;
  logic        pixel_rd;
  logic [23:0] pixel_data;
  logic        dout;
  logic        led_clock;
  logic        encoder_finished;
  logic        busy;
  logic        overrun;

  modport master (
    output led_selected, led_counter, done, pixel_data,
    input  pixel_addr, pixel_rd, dout, led_clock, encoder_finished, busy, overrun
  );

  modport slave (
    input  led_selected, led_counter, done, pixel_data,
    output pixel_addr, pixel_rd, dout, led_clock, encoder_finished, busy, overrun
  );
endinterface

// File: rtl/ws2812_encoder.sv
// Serialises one 24-bit GRB pixel per LED into the WS2812 single-wire waveform.
// Every output is a flop computed from next-state values, so dout and led_clock are glitch-free.
module ws2812_encoder #(
  parameter int T0H_CYCLES   = 4,
  parameter int T1H_CYCLES   = 8,
  parameter int BIT_CYCLES   = 15,
  parameter int LATCH_CYCLES = 720
) (
  input logic             clock_12mhz,
  input logic             led_counter_reset,
  ws2812_encoder_if.slave bus
);

  typedef enum logic [2:0] {
    START, FETCH, CAPTURE, SEND, NEXT, IDLE_WAIT, LATCH, FINISHED
  } state_t;

  localparam logic [3:0] PHASE_LAST = 4'(BIT_CYCLES - 1);
  localparam logic [4:0] T0H        = 5'(T0H_CYCLES);
  localparam logic [4:0] T1H        = 5'(T1H_CYCLES);
  localparam logic [9:0] LATCH_LAST = 10'(LATCH_CYCLES - 1);
  localparam logic [4:0] LAST_BIT   = 5'd23;

  state_t      state, state_next;
  logic [3:0]  phase, phase_next;
  logic [4:0]  bit_cnt, bit_cnt_next;
  logic [23:0] shift, shift_next;
  logic [9:0]  latch_cnt, latch_cnt_next;
  logic        pending_led, pending_led_next;
  logic        pending_done, pending_done_next;
  logic [7:0]  pending_index, pending_index_next;
  logic        overrun, overrun_next;
  logic [7:0]  pixel_addr, pixel_addr_next;
  logic        pixel_rd, pixel_rd_next;
  logic        dout, dout_next;
  logic        led_clock, led_clock_next;
  logic        encoder_finished, encoder_finished_next;
  logic        busy, busy_next;

  always_ff @(posedge clock_12mhz or posedge led_counter_reset) begin
    if (led_counter_reset) begin
      state            <= START;
      phase            <= '0;
      bit_cnt          <= '0;
      shift            <= '0;
      latch_cnt        <= '0;
      pending_led      <= 1'b0;
      pending_done     <= 1'b0;
      pending_index    <= '0;
      overrun          <= 1'b0;
      pixel_addr       <= '0;
      pixel_rd         <= 1'b0;
      dout             <= 1'b0;
      led_clock        <= 1'b0;
      encoder_finished <= 1'b0;
      busy             <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
      state            <= state_next;
      phase            <= phase_next;
      bit_cnt          <= bit_cnt_next;
      shift            <= shift_next;
      latch_cnt        <= latch_cnt_next;
      pending_led      <= pending_led_next;
      pending_done     <= pending_done_next;
      pending_index    <= pending_index_next;
      overrun          <= overrun_next;
      pixel_addr       <= pixel_addr_next;
      pixel_rd         <= pixel_rd_next;
      dout             <= dout_next;
      led_clock        <= led_clock_next;
      encoder_finished <= encoder_finished_next;
      busy             <= busy_next;
    end
  end

  always_comb begin
    // NOTE: every signal gets its hold value first, so no path through the case leaves one unassigned (no latch).
    state_next         = state;
    phase_next         = phase;
    bit_cnt_next       = bit_cnt;
    shift_next         = shift;
    latch_cnt_next     = latch_cnt;
    pending_led_next   = pending_led;
    pending_done_next  = pending_done;
    pending_index_next = pending_index;
    overrun_next       = overrun;
    pixel_addr_next    = pixel_addr;

    // Requests are latched in every state; a second request before the first is serviced is dropped.
    if (bus.led_selected) begin
      if (pending_led) begin
        overrun_next = 1'b1;
      end else begin
        pending_led_next   = 1'b1;
        pending_index_next = bus.led_counter;
      end
    end
    if (bus.done) pending_done_next = 1'b1;

    unique case (state)
      START: begin
        state_next      = FETCH;
        pixel_addr_next = bus.led_counter;
      end
      FETCH: state_next = CAPTURE;
      CAPTURE: begin
        shift_next   = bus.pixel_data;
        bit_cnt_next = LAST_BIT;
        phase_next   = '0;
        state_next   = SEND;
      end
      SEND: begin
        if (phase == PHASE_LAST) begin
          if (bit_cnt == 5'd0) begin
            state_next = NEXT;
          end else begin
            shift_next   = {shift[22:0], 1'b0};
            bit_cnt_next = bit_cnt - 5'd1;
            phase_next   = '0;
          end
        end else begin
          phase_next = phase + 4'd1;
        end
      end
      NEXT: state_next = IDLE_WAIT;
      IDLE_WAIT: begin
        // Looking at the next-flag values lets a pulse arriving here start FETCH on the following cycle.
        if (pending_led_next) begin
          state_next       = FETCH;
          pending_led_next = 1'b0;
          pixel_addr_next  = pending_index_next;
        end else if (pending_done_next) begin
          state_next        = LATCH;
          pending_done_next = 1'b0;
          latch_cnt_next    = '0;
        end
      end
      LATCH: begin
        if (latch_cnt == LATCH_LAST) state_next = FINISHED;
        else                         latch_cnt_next = latch_cnt + 10'd1;
      end
      FINISHED: state_next = FINISHED;
    endcase

    dout_next             = (state_next == SEND) &&
                            ({1'b0, phase_next} < (shift_next[23] ? T1H : T0H));
    pixel_rd_next         = (state_next == FETCH);
    led_clock_next        = (state_next == NEXT) || (state == NEXT);
    encoder_finished_next = (state_next == NEXT);
    busy_next             = !((state_next == IDLE_WAIT) || (state_next == FINISHED));
  end

  assign bus.pixel_addr       = pixel_addr;
  assign bus.pixel_rd         = pixel_rd;
  assign bus.dout             = dout;
  assign bus.led_clock        = led_clock;
  assign bus.encoder_finished = encoder_finished;
  assign bus.busy             = busy;
  assign bus.overrun          = overrun;

endmodule

// File: tb/tb_ws2812_encoder.sv
// Scoreboard bench for ws2812_encoder: a selector model and frame buffer drive it,
// a monitor decodes dout by high time and checks each LED against the expected queue.
module tb_ws2812_encoder;
  localparam int T0H = 4, T1H = 8, BIT = 15, LATCH = 720;

  typedef struct {
    logic [7:0]  addr;
    logic [23:0] pix;
  } led_t;

  logic clock_12mhz = 1'b0;
  logic led_counter_reset = 1'b1;
  ws2812_encoder_if bus ();

  ws2812_encoder #(
    .T0H_CYCLES(T0H), .T1H_CYCLES(T1H), .BIT_CYCLES(BIT), .LATCH_CYCLES(LATCH)
  ) dut (
    .clock_12mhz(clock_12mhz),
    .led_counter_reset(led_counter_reset),
    .bus(bus)
  );

  always #5 clock_12mhz = ~clock_12mhz;

  logic [23:0] fb [256];
  led_t sb [$];
  int n_checks = 0, n_err = 0;
  int n_fin = 0, n_rd = 0;
  bit sel_en = 1'b0;
  int sel_idx = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock_12mhz);
    #1;
  endtask

  function automatic logic [63:0] outs();
    return {50'b0, bus.pixel_addr, bus.pixel_rd, bus.dout, bus.led_clock,
            bus.encoder_finished, bus.busy, bus.overrun};
  endfunction

  // Frame buffer: data for the address read in the previous cycle, noise otherwise.
  initial begin
    logic       prev_rd = 1'b0;
    logic [7:0] prev_addr = '0;
    bus.pixel_data = '0;
    forever begin
      @(posedge clock_12mhz);
      #1;
      bus.pixel_data = prev_rd ? fb[prev_addr] : 24'($urandom);
      prev_rd   = bus.pixel_rd;
      prev_addr = bus.pixel_addr;
    end
  end

  // Selector model: each led_clock rise steps the index down, or reports done after index 0.
  initial begin
    logic lc_prev = 1'b0;
    forever begin
      @(posedge clock_12mhz);
      #1;
      if (sel_en && bus.led_clock && !lc_prev) begin
        repeat (3) begin @(posedge clock_12mhz); #1; end
        if (sel_idx > 0) begin
          sel_idx--;
          bus.led_counter  = 8'(sel_idx);
          bus.led_selected = 1'b1;
          sb.push_back('{addr: 8'(sel_idx), pix: fb[sel_idx]});
        end else begin
          bus.done = 1'b1;
        end
        @(posedge clock_12mhz);
        #1;
        bus.led_selected = 1'b0;
        bus.done         = 1'b0;
      end
      lc_prev = bus.led_clock;
    end
  end

  // Monitor: decode dout by high time, compare each finished LED with the scoreboard head.
  initial begin
    int hi = 0, lo = 0, nbits = 0, terr = 0, last_hi = 0;
    logic [23:0] word = '0;
    logic [7:0]  rd_addr = '0;
    logic        prev = 1'b0;
    led_t        exp;
    forever begin
      @(negedge clock_12mhz);
      if (led_counter_reset) begin
        hi = 0; lo = 0; nbits = 0; terr = 0; word = '0; prev = 1'b0;
      end else begin
        if (bus.pixel_rd) begin
          rd_addr = bus.pixel_addr;
          n_rd++;
        end
        if (bus.encoder_finished) begin
          if (nbits > 0 && last_hi + lo != BIT) terr++;
          n_fin++;
          check("led_expected", 64'(sb.size() > 0), 64'd1);
          if (sb.size() > 0) begin
            exp = sb.pop_front();
            check("pixel_addr", 64'(rd_addr), 64'(exp.addr));
            check("pixel_value", 64'(word), 64'(exp.pix));
            check("bit_count", 64'(nbits), 64'd24);
            check("bit_timing", 64'(terr), 64'd0);
          end
          hi = 0; lo = 0; nbits = 0; terr = 0; word = '0;
        end else if (bus.dout) begin
          if (!prev) begin
            if (nbits > 0 && last_hi + lo != BIT) terr++;
            hi = 0;
          end
          hi++;
        end else begin
          if (prev) begin
            if (hi != T1H && hi != T0H) terr++;
            word = {word[22:0], (hi == T1H)};
            nbits++;
            last_hi = hi;
            lo = 0;
          end
          lo++;
        end
        prev = bus.dout;
      end
    end
  end

  task automatic start_frame(input int idx, input bit auto_sel);
    sel_en = 1'b0;
    bus.led_selected = 1'b0;
    bus.done = 1'b0;
    bus.led_counter = 8'(idx);
    led_counter_reset = 1'b1;
    tick(2);
    check("reset_outputs", outs(), 64'd0);
    sb.delete();
    sb.push_back('{addr: 8'(idx), pix: fb[idx]});
    sel_idx = idx;
    sel_en = auto_sel;
    led_counter_reset = 1'b0;
  endtask

  task automatic wait_fin(input string name, input int target, input int budget);
    int k = 0;
    while (n_fin < target && k < budget) begin
      tick(1);
      k++;
    end
    check(name, 64'(n_fin >= target), 64'd1);
  endtask

  task automatic pulse_select(input int idx, input bit with_done);
    bus.led_counter  = 8'(idx);
    bus.led_selected = 1'b1;
    bus.done         = with_done;
    tick(1);
    bus.led_selected = 1'b0;
    bus.done         = 1'b0;
  endtask

  task automatic measure_latch(input string name);
    int k = 0, len = 0, high = 0;
    while (!bus.busy && k < 20) begin
      tick(1);
      k++;
    end
    check({name, "_latch_start"}, 64'(bus.busy), 64'd1);
    while (bus.busy && len < 2000) begin
      if (bus.dout) high++;
      len++;
      tick(1);
    end
    check({name, "_latch_len"}, 64'(len), 64'(LATCH));
    check({name, "_latch_dout"}, 64'(high), 64'd0);
    tick(5);
    check({name, "_finished"}, {61'b0, bus.busy, bus.dout, bus.led_clock}, 64'd0);
  endtask

  initial begin
    int cyc, first_rise, rd_cyc, lc, base, rd_base;
    logic [7:0] rd_seen;
    bus.led_selected = 1'b0;
    bus.done = 1'b0;
    bus.led_counter = '0;
    for (int i = 0; i < 256; i++) fb[i] = 24'($urandom);

    // Single LED from reset: addressing, first-bit latency, finish cycle, led_clock width.
    fb[149] = 24'hFF0000;
    base = n_fin;
    start_frame(149, 1'b0);
    cyc = 0; first_rise = -1; rd_cyc = -1; rd_seen = '0;
    while (!bus.encoder_finished && cyc < 500) begin
      tick(1);
      cyc++;
      if (bus.dout && first_rise < 0) first_rise = cyc;
      if (bus.pixel_rd && rd_cyc < 0) begin
        rd_cyc = cyc;
        rd_seen = bus.pixel_addr;
      end
    end
    check("single_finish_cycle", 64'(cyc), 64'd363);
    check("single_first_rise", 64'(first_rise), 64'd3);
    check("single_rd_cycle", 64'(rd_cyc), 64'd1);
    check("single_rd_addr", 64'(rd_seen), 64'd149);
    lc = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.led_clock) lc++;
      tick(1);
    end
    check("led_clock_width", 64'(lc), 64'd2);
    tick(10);
    check("single_led_count", 64'(n_fin - base), 64'd1);
    check("single_idle_busy", 64'(bus.busy), 64'd0);

    // Chained frame 149..0 with random pixels, then the latch gap.
    base = n_fin;
    start_frame(149, 1'b1);
    wait_fin("chain_wait", base + 150, 150 * 400);
    measure_latch("chain");
    check("chain_led_count", 64'(n_fin - base), 64'd150);
    check("chain_overrun", 64'(bus.overrun), 64'd0);
    check("chain_sb_empty", 64'(sb.size()), 64'd0);

    // Bit accuracy, then led_selected and done together in IDLE_WAIT.
    fb[7] = 24'hA5C33C;
    base = n_fin;
    start_frame(7, 1'b0);
    wait_fin("accuracy_wait", base + 1, 500);
    tick(10);
    check("simul_idle_busy", 64'(bus.busy), 64'd0);
    sb.push_back('{addr: 8'd12, pix: fb[12]});
    pulse_select(12, 1'b1);
    wait_fin("simul_wait", base + 2, 500);
    measure_latch("simul");
    check("simul_led_count", 64'(n_fin - base), 64'd2);
    check("simul_overrun", 64'(bus.overrun), 64'd0);
    rd_base = n_rd;
    pulse_select(33, 1'b0);
    tick(30);
    check("finished_no_fetch", 64'(n_rd - rd_base), 64'd0);
    check("finished_no_led", 64'(n_fin - base), 64'd2);

    // Overrun: two requests during SEND, only the first is served.
    base = n_fin;
    start_frame(20, 1'b0);
    tick(50);
    sb.push_back('{addr: 8'd30, pix: fb[30]});
    pulse_select(30, 1'b0);
    tick(20);
    check("overrun_after_one", 64'(bus.overrun), 64'd0);
    pulse_select(40, 1'b0);
    check("overrun_set", 64'(bus.overrun), 64'd1);
    wait_fin("overrun_wait", base + 2, 1000);
    tick(800);
    check("overrun_led_count", 64'(n_fin - base), 64'd2);
    check("overrun_sticky", 64'(bus.overrun), 64'd1);
    check("overrun_sb_empty", 64'(sb.size()), 64'd0);

    // Reset five cycles into the high phase of a 1 bit, then restart a short frame.
    fb[3][23] = 1'b1;
    base = n_fin;
    start_frame(3, 1'b0);
    cyc = 0;
    while (!bus.dout && cyc < 50) begin
      tick(1);
      cyc++;
    end
    tick(4);
    check("midbit_high_before", 64'(bus.dout), 64'd1);
    led_counter_reset = 1'b1;
    #1;
    check("midbit_async_clear", outs(), 64'd0);
    tick(1);
    check("midbit_no_led", 64'(n_fin - base), 64'd0);
    start_frame(5, 1'b1);
    wait_fin("restart_wait", base + 6, 6 * 400);
    measure_latch("restart");
    check("restart_led_count", 64'(n_fin - base), 64'd6);
    check("restart_sb_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
